// File: rtl/fifo_word_packer_if.sv
// Bundle of the sync_fifo read port and the packed-word output stream.
// The packer drives through "master"; the FIFO/downstream side uses "slave".
interface fifo_word_packer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = 4
);
    localparam int CNT_W = $clog2(PACK + 1);

    logic                         fifo_rd_en;
    logic                         fifo_rd_empty;
    logic [DATA_WIDTH-1:0]        fifo_rd_data;
    logic                         out_valid;
    logic                         out_ready;
    logic [DATA_WIDTH*PACK-1:0]   out_data;
    logic [CNT_W-1:0]             out_cnt;

    modport master (
        output fifo_rd_en,
        input  fifo_rd_empty,
        input  fifo_rd_data,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_cnt
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_rd_empty,
        output fifo_rd_data,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_cnt
    );
endinterface

// File: rtl/fifo_word_packer.sv
// Pops entries from sync_fifo and packs PACK of them into one valid/ready word.
// Define PACKER_FLUSH_EN to emit partial words after TIMEOUT idle cycles.
module fifo_word_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic               clk,
    input  logic               rst,
    fifo_word_packer_if.master bus
);
    localparam int OUT_WIDTH = DATA_WIDTH * PACK;
    localparam int CNT_W     = $clog2(PACK + 1);
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(PACK);
    localparam logic [CNT_W:0]   PACK_WIDE  = (CNT_W + 1)'(PACK);

    logic [OUT_WIDTH-1:0] asm_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 pend_q;
    logic [OUT_WIDTH-1:0] out_data_q;
    logic [CNT_W-1:0]     out_cnt_q;
    logic                 out_valid_q;

    logic [CNT_W:0]       lanes_claimed;
    logic                 pop;
    logic                 out_free;
    logic                 word_ready;
    logic                 flush_go;

    // A pop in flight already owns a lane, so it counts against the free space.
    assign lanes_claimed = {1'b0, cnt_q} + {{CNT_W{1'b0}}, pend_q};
    assign pop           = !rst && !bus.fifo_rd_empty && (lanes_claimed < PACK_WIDE);
    assign out_free      = !out_valid_q || bus.out_ready;
    assign word_ready    = (cnt_q == FULL_CNT) && out_free;

`ifdef PACKER_FLUSH_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);

    logic [IDLE_W-1:0] idle_q;

    assign flush_go = (idle_q == IDLE_MAX) && (cnt_q != '0) && !pend_q && !pop && out_free;

    // Idle only while a partial word sits with nothing arriving; saturates at TIMEOUT.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_q <= '0;
        end else if (pop || pend_q || (cnt_q == '0) || flush_go) begin
            idle_q <= '0;
        end else if (bus.fifo_rd_empty && (idle_q != IDLE_MAX)) begin
            idle_q <= idle_q + 1'b1;
        end
    end
`else
    assign flush_go = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            asm_q       <= '0;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            out_data_q  <= '0;
            out_cnt_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            pend_q <= pop;
            if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (pend_q) begin
                for (int i = 0; i < PACK; i++) begin
                    if (cnt_q == CNT_W'(i)) begin
                        asm_q[i*DATA_WIDTH +: DATA_WIDTH] <= bus.fifo_rd_data;
                    end
                end
                cnt_q <= cnt_q + 1'b1;
            end else if (word_ready || flush_go) begin
                // asm is cleared on every hand-off, so unused lanes of a partial word read zero.
                out_data_q  <= asm_q;
                out_cnt_q   <= cnt_q;
                out_valid_q <= 1'b1;
                asm_q       <= '0;
                cnt_q       <= '0;
            end
        end
    end

    assign bus.fifo_rd_en = pop;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_cnt    = out_cnt_q;
endmodule

// File: tb/tb_fifo_word_packer.sv
// Scoreboard bench for fifo_word_packer driven by a small behavioural 8-deep sync_fifo.
// Build with PACKER_FLUSH_EN defined to expect the partial-word flush.
module tb_fifo_word_packer;
    logic       clk = 1'b0;
    logic       rst;
    logic       fifo_rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       out_ready;

    logic [7:0] mem [8];
    logic [2:0] wp, rp;
    logic [3:0] fifo_count;
    logic [7:0] rd_data_q;
    logic       wr_full, do_wr, do_rd;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  cnt;
    } word_t;

    word_t       exp_q[$];
    logic [31:0] acc;
    int          lanes;
    int          total = 0;
    int          bad = 0;
    int          pops, empty_pops, valid_cycles, words;

    fifo_word_packer_if #(.DATA_WIDTH(8), .PACK(4)) bus ();

    fifo_word_packer #(.DATA_WIDTH(8), .PACK(4), .TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    assign wr_full           = (fifo_count == 4'd8);
    assign do_wr             = wr_en && !wr_full;
    assign do_rd             = bus.fifo_rd_en && (fifo_count != 4'd0);
    assign bus.fifo_rd_empty = (fifo_count == 4'd0);
    assign bus.fifo_rd_data  = rd_data_q;
    assign bus.out_ready     = out_ready;

    // Behavioural sync_fifo: registered read data, valid the cycle after the pop edge.
    always @(posedge clk) begin
        if (fifo_rst) begin
            wp         <= '0;
            rp         <= '0;
            fifo_count <= '0;
            rd_data_q  <= '0;
        end else begin
            if (do_wr) begin
                mem[wp] <= wr_data;
                wp      <= wp + 3'd1;
            end
            if (do_rd) begin
                rd_data_q <= mem[rp];
                rp        <= rp + 3'd1;
            end
            fifo_count <= fifo_count + {3'b0, do_wr} - {3'b0, do_rd};
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, wanted %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output monitor sampled mid-cycle; a handshake seen here completes on the next edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.fifo_rd_en) pops++;
            if (bus.fifo_rd_en && bus.fifo_rd_empty) empty_pops++;
            if (bus.out_valid) valid_cycles++;
            if (bus.out_valid && out_ready) begin
                word_t e;
                words++;
                checkOutput("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    checkOutput("word_data", 64'(bus.out_data), 64'(e.data));
                    checkOutput("word_cnt", 64'(bus.out_cnt), 64'(e.cnt));
                end
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] d);
        int guard = 0;
        while (wr_full && guard < 100) begin
            tick();
            guard++;
        end
        if (guard >= 100) checkOutput("wr_full_timeout", 64'(wr_full), 64'd0);
        wr_en   = 1'b1;
        wr_data = d;
        acc[lanes*8 +: 8] = d;
        lanes++;
        if (lanes == 4) begin
            exp_q.push_back({acc, 3'd4});
            acc   = '0;
            lanes = 0;
        end
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst      = 1'b1;
        fifo_rst = 1'b1;
        repeat (n) tick();
        rst      = 1'b0;
        fifo_rst = 1'b0;
        exp_q.delete();
        acc   = '0;
        lanes = 0;
    endtask

    task automatic wait_words(input string tag, input int n, input int budget);
        int k = 0;
        while (words < n && k < budget) begin
            tick();
            k++;
        end
        checkOutput(tag, 64'(words), 64'(n));
    endtask

    initial begin
        int cyc;
        int stable;
        rst = 1'b1; fifo_rst = 1'b1; wr_en = 1'b0; wr_data = '0; out_ready = 1'b0;
        acc = '0; lanes = 0; pops = 0; empty_pops = 0; valid_cycles = 0; words = 0;
        tick();
        fifo_rst = 1'b0;

        // Reset held while the FIFO holds three entries.
        applyStimulus(8'hA1); applyStimulus(8'hA2); applyStimulus(8'hA3);
        repeat (2) tick();
        checkOutput("rst_rd_en", 64'(bus.fifo_rd_en), 64'd0);
        checkOutput("rst_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("rst_data", 64'(bus.out_data), 64'd0);
        checkOutput("rst_cnt", 64'(bus.out_cnt), 64'd0);
        do_reset(2);

        // Basic pack.
        out_ready = 1'b1;
        pops = 0; valid_cycles = 0; words = 0;
        applyStimulus(8'h11); applyStimulus(8'h22); applyStimulus(8'h33); applyStimulus(8'h44);
        wait_words("pack_word", 1, 50);
        repeat (5) tick();
        checkOutput("pack_pops", 64'(pops), 64'd4);
        checkOutput("pack_valid_cycles", 64'(valid_cycles), 64'd1);

        // Backpressure.
        out_ready = 1'b0;
        pops = 0; words = 0; stable = 0;
        for (int i = 1; i <= 8; i++) applyStimulus(8'(i));
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.out_valid && bus.out_data == 32'h04030201) stable++;
        end
        checkOutput("bp_hold", 64'(stable), 64'd20);
        checkOutput("bp_pops", 64'(pops), 64'd8);
        checkOutput("bp_fifo_empty", 64'(bus.fifo_rd_empty), 64'd1);
        out_ready = 1'b1;
        wait_words("bp_words", 2, 40);

        // Drain from a full FIFO.
        do_reset(1);
        out_ready = 1'b0;
        words = 0;
        for (int i = 0; i < 16; i++) applyStimulus(8'h80 + 8'(i));
        repeat (5) tick();
        checkOutput("drain_full", 64'(wr_full), 64'd1);
        out_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 60) begin
            tick();
            cyc++;
        end
        checkOutput("drain_done", 64'(exp_q.size()), 64'd0);
        checkOutput("drain_time_ok", 64'(cyc <= 20), 64'd1);

        // Partial word.
        do_reset(1);
        out_ready = 1'b1;
        words = 0;
        applyStimulus(8'hAA); applyStimulus(8'hBB);
`ifdef PACKER_FLUSH_EN
        exp_q.push_back({acc, 3'(lanes)});
        acc = '0; lanes = 0;
        wait_words("flush_word", 1, 60);
`else
        repeat (100) tick();
        checkOutput("no_partial", 64'(words), 64'd0);
`endif

        // Reset with two lanes captured and a pop in flight.
        do_reset(1);
        applyStimulus(8'hE1); applyStimulus(8'hE2); applyStimulus(8'hE3);
        tick();
        do_reset(1);
        words = 0;
        applyStimulus(8'h5A); applyStimulus(8'h6B); applyStimulus(8'h7C); applyStimulus(8'h8D);
        wait_words("midrst_word", 1, 50);
        repeat (10) tick();
        checkOutput("midrst_only_one", 64'(words), 64'd1);
        checkOutput("sb_drained", 64'(exp_q.size()), 64'd0);
        checkOutput("no_empty_pops", 64'(empty_pops), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
